// File: rtl/ldpc_dvb_enc_obuf_rd_ctrl.sv
// ldpc_dvb_enc_obuf_rd_ctrl: reads a finished codeword (data then parity) out of the ping-pong output buffer
module ldpc_dvb_enc_obuf_rd_ctrl #(
  parameter int pCOL_W  = 8,
  parameter int pROW_W  = 9,
  parameter int pADDR_W = 10,
  parameter int pPBASE  = 512,
  parameter int pRD_LAT = 2
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iclkena,
  input  logic               ibuf_full,
  output logic               obuf_empty,
  input  logic [pCOL_W-1:0]  iused_data_col,
  input  logic [pROW_W-1:0]  iused_row,
  input  logic               iordy,
  output logic               oread,
  output logic               obank,
  output logic [pADDR_W-1:0] oaddr,
  output logic               oval,
  output logic               osof,
  output logic               osop,
  output logic               oeop,
  output logic               oeof,
  output logic               opar,
  output logic               obusy
);
  typedef enum logic [2:0] {
    cRESET_STATE, cWAIT_STATE, cINIT_STATE, cDATA_STATE, cPAR_STATE, cFLUSH_STATE, cDONE_STATE
  } state_t;
  state_t state_q, state_d;
  logic bank_q, bank_d;
  logic [pCOL_W-1:0] data_cnt_q, data_cnt_d, data_end_q, data_end_d;
  logic [pROW_W-1:0] par_cnt_q, par_cnt_d, par_end_q, par_end_d;
  logic [pRD_LAT-1:0][5:0] pipe_q, pipe_d;
  logic [5:0] tag;
  logic in_data, in_par, data_last, par_last;
  always_comb begin
    in_data = state_q == cDATA_STATE;
    in_par = state_q == cPAR_STATE;
    data_last = data_cnt_q == data_end_q;
    par_last = par_cnt_q == par_end_q;
    oread = (in_data | in_par) & iordy;
    obank = bank_q;
    oaddr = in_par ? pADDR_W'(pPBASE) + pADDR_W'(par_cnt_q) : in_data ? pADDR_W'(data_cnt_q) : '0;
    // tag = {val, sof, sop, eop, eof, par}
    tag = !oread ? '0
        : in_data ? {1'b1, data_cnt_q == '0, data_cnt_q == '0, data_last, 1'b0, 1'b0}
        : {1'b1, 1'b0, par_cnt_q == '0, par_last, par_last, 1'b1};
    pipe_d[0] = tag;
    for (int i = 1; i < pRD_LAT; i++) pipe_d[i] = pipe_q[i-1];
    {oval, osof, osop, oeop, oeof, opar} = pipe_q[pRD_LAT-1];
    obuf_empty = state_q == cDONE_STATE;
    obusy = state_q != cWAIT_STATE;
    state_d = state_q;
    bank_d = bank_q;
    data_cnt_d = data_cnt_q;
    data_end_d = data_end_q;
    par_cnt_d = par_cnt_q;
    par_end_d = par_end_q;
    case (state_q)
      cRESET_STATE: state_d = cWAIT_STATE;
      cWAIT_STATE:  state_d = ibuf_full ? cINIT_STATE : cWAIT_STATE;
      cINIT_STATE: begin
        data_cnt_d = '0;
        par_cnt_d = '0;
        data_end_d = iused_data_col == '0 ? '0 : iused_data_col - 1'b1;
        par_end_d = iused_row == '0 ? '0 : iused_row - 1'b1;
        state_d = cDATA_STATE;
      end
      cDATA_STATE: if (iordy) begin
        data_cnt_d = data_cnt_q + 1'b1;
        state_d = data_last ? cPAR_STATE : cDATA_STATE;
      end
      cPAR_STATE: if (iordy) begin
        par_cnt_d = par_cnt_q + 1'b1;
        state_d = par_last ? cFLUSH_STATE : cPAR_STATE;
      end
      cFLUSH_STATE: state_d = pipe_q == '0 ? cDONE_STATE : cFLUSH_STATE;
      cDONE_STATE: begin
        bank_d = ~bank_q;
        state_d = cWAIT_STATE;
      end
      default: state_d = cRESET_STATE;
    endcase
  end
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      state_q <= cRESET_STATE;
      bank_q <= 1'b0;
      data_cnt_q <= '0;
      data_end_q <= '0;
      par_cnt_q <= '0;
      par_end_q <= '0;
      pipe_q <= '0;
    end else if (iclkena) begin
      state_q <= state_d;
      bank_q <= bank_d;
      data_cnt_q <= data_cnt_d;
      data_end_q <= data_end_d;
      par_cnt_q <= par_cnt_d;
      par_end_q <= par_end_d;
      pipe_q <= pipe_d;
    end
  end
endmodule

// File: tb/tb_ldpc_dvb_enc_obuf_rd_ctrl.sv
// tb_ldpc_dvb_enc_obuf_rd_ctrl: directed scenarios against hand-computed read/strobe sequences
module tb_ldpc_dvb_enc_obuf_rd_ctrl;
  localparam int LAT = 2;
  logic iclk = 0, ireset = 0, iclkena = 1, ibuf_full = 0, iordy = 1;
  logic [7:0] iused_data_col = '0;
  logic [8:0] iused_row = '0;
  logic obuf_empty, oread, obank, oval, osof, osop, oeop, oeof, opar, obusy;
  logic [9:0] oaddr;
  int vectors = 0, errors = 0, cyc = 0, exp_bank = 0, bad_overlap = 0, bad_rd = 0;
  logic [10:0] rd_q[$];
  logic [4:0] wd_q[$];
  int rd_cyc[$], val_cyc[$], emp_cyc[$];

  ldpc_dvb_enc_obuf_rd_ctrl dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ibuf_full(ibuf_full),
    .obuf_empty(obuf_empty), .iused_data_col(iused_data_col), .iused_row(iused_row),
    .iordy(iordy), .oread(oread), .obank(obank), .oaddr(oaddr), .oval(oval),
    .osof(osof), .osop(osop), .oeop(oeop), .oeof(oeof), .opar(opar), .obusy(obusy)
  );

  always #5 iclk = ~iclk;
  always @(posedge iclk) cyc <= cyc + 1;

  // record only cycles that the next clock edge will actually commit
  always @(negedge iclk) if (ireset && iclkena) begin
    if (oread) begin
      rd_q.push_back({obank, oaddr});
      rd_cyc.push_back(cyc);
      if (!iordy) bad_rd++;
    end
    if (oval) begin
      wd_q.push_back({osof, osop, oeop, oeof, opar});
      val_cyc.push_back(cyc);
    end
    if (obuf_empty) begin
      emp_cyc.push_back(cyc);
      if (oval) bad_overlap++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic clear_mon();
    rd_q.delete(); wd_q.delete(); rd_cyc.delete(); val_cyc.delete(); emp_cyc.delete();
    bad_overlap = 0;
    bad_rd = 0;
  endtask

  task automatic do_frame(input int d, input int r, input bit gap, input bit stall);
    int n0;
    bit stalled;
    n0 = emp_cyc.size();
    stalled = 0;
    iused_data_col = 8'(d);
    iused_row = 9'(r);
    ibuf_full = 1;
    iordy = 1;
    for (int i = 0; i < 300 && emp_cyc.size() == n0; i++) begin
      tick();
      if (obusy) ibuf_full = 0;
      if (gap) iordy = ~iordy;
      if (stall && !stalled && oread && oaddr == 10'd1) begin
        iclkena = 0;
        for (int k = 0; k < 3; k++) begin
          tick();
          vectors++;
          if ({oread, oaddr, oval} !== {1'b1, 10'd1, 1'b0}) begin
            errors++;
            $display("FAIL stall_hold[%0d]: oread/oaddr/oval=%b/%0d/%b, expected 1/1/0", k, oread, oaddr, oval);
          end
        end
        iclkena = 1;
        stalled = 1;
      end
    end
    iordy = 1;
    vectors++;
    if (emp_cyc.size() != n0 + 1) begin
      errors++;
      $display("FAIL frame_done: obuf_empty pulses=%0d, expected 1", emp_cyc.size() - n0);
    end else exp_bank ^= 1;
    tick();
    tick();
  endtask

  task automatic test_frame_seq(input string nm, input int d, input int r, input bit gap, input bit stall,
                                input logic [4:0] et[$], input logic [9:0] ea[$]);
    int b, lat;
    b = exp_bank;
    clear_mon();
    do_frame(d, r, gap, stall);
    vectors++;
    if (rd_q.size() != ea.size()) begin
      errors++;
      $display("FAIL %s_nreads: got %0d, expected %0d", nm, rd_q.size(), ea.size());
    end
    vectors++;
    if (wd_q.size() != et.size()) begin
      errors++;
      $display("FAIL %s_nwords: got %0d, expected %0d", nm, wd_q.size(), et.size());
    end
    for (int i = 0; i < ea.size() && i < rd_q.size(); i++) begin
      vectors++;
      if (rd_q[i] !== {b[0], ea[i]}) begin
        errors++;
        $display("FAIL %s_addr[%0d]: bank/addr=%0d/%0d, expected %0d/%0d", nm, i, rd_q[i][10], rd_q[i][9:0], b[0], ea[i]);
      end
    end
    for (int i = 0; i < et.size() && i < wd_q.size(); i++) begin
      vectors++;
      if (wd_q[i] !== et[i]) begin
        errors++;
        $display("FAIL %s_tags[%0d]: sof,sop,eop,eof,par=%b, expected %b", nm, i, wd_q[i], et[i]);
      end
    end
    for (int i = 0; i < rd_cyc.size() && i < val_cyc.size(); i++) begin
      lat = (stall && i == 0) ? LAT + 3 : LAT;
      vectors++;
      if (val_cyc[i] - rd_cyc[i] != lat) begin
        errors++;
        $display("FAIL %s_latency[%0d]: got %0d, expected %0d", nm, i, val_cyc[i] - rd_cyc[i], lat);
      end
    end
    vectors++;
    if (bad_overlap != 0 || bad_rd != 0) begin
      errors++;
      $display("FAIL %s_protocol: empty-with-val=%0d read-without-ready=%0d, expected 0/0", nm, bad_overlap, bad_rd);
    end
    vectors++;
    if (obank !== exp_bank[0]) begin
      errors++;
      $display("FAIL %s_bank_after: obank=%b, expected %b", nm, obank, exp_bank[0]);
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    vectors++;
    if ({oread, oval, osof, osop, oeop, oeof, opar, obuf_empty} !== 8'h00) begin
      errors++;
      $display("FAIL reset_strobes: got %b, expected 00000000", {oread, oval, osof, osop, oeop, oeof, opar, obuf_empty});
    end
    vectors++;
    if (obank !== 1'b0) begin errors++; $display("FAIL reset_bank: obank=%b, expected 0", obank); end
    vectors++;
    if (oaddr !== 10'd0) begin errors++; $display("FAIL reset_addr: oaddr=%0d, expected 0", oaddr); end
    vectors++;
    if (obusy !== 1'b1) begin errors++; $display("FAIL reset_busy: obusy=%b, expected 1", obusy); end
    ireset = 1;
    tick();
    vectors++;
    if (obusy !== 1'b0) begin errors++; $display("FAIL wait_idle: obusy=%b, expected 0", obusy); end
  endtask

  task automatic test_basic();
    logic [4:0] et[$];
    logic [9:0] ea[$];
    et = {5'b11000, 5'b00000, 5'b00100, 5'b01001, 5'b00111};
    ea = {10'd0, 10'd1, 10'd2, 10'd512, 10'd513};
    test_frame_seq("basic", 3, 2, 0, 0, et, ea);
  endtask

  task automatic test_ready_gaps();
    logic [4:0] et[$];
    logic [9:0] ea[$];
    et = {5'b11000, 5'b00000, 5'b00100, 5'b01001, 5'b00111};
    ea = {10'd0, 10'd1, 10'd2, 10'd512, 10'd513};
    test_frame_seq("gaps", 3, 2, 1, 0, et, ea);
  endtask

  task automatic test_min_frame();
    logic [4:0] et[$];
    logic [9:0] ea[$];
    et = {5'b11100, 5'b01111};
    ea = {10'd0, 10'd512};
    test_frame_seq("min", 1, 1, 0, 0, et, ea);
    test_frame_seq("zero", 0, 0, 0, 0, et, ea);
  endtask

  task automatic test_back_to_back();
    logic [9:0] ea[$];
    int b;
    b = exp_bank;
    ea = {10'd0, 10'd1, 10'd512};
    clear_mon();
    iused_data_col = 8'd2;
    iused_row = 9'd1;
    ibuf_full = 1;
    for (int i = 0; i < 400 && emp_cyc.size() < 2; i++) tick();
    ibuf_full = 0;
    tick();
    tick();
    vectors++;
    if (emp_cyc.size() != 2) begin errors++; $display("FAIL b2b_empties: got %0d, expected 2", emp_cyc.size()); end
    vectors++;
    if (rd_q.size() != 6) begin
      errors++;
      $display("FAIL b2b_nreads: got %0d, expected 6", rd_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (rd_q[i] !== {b[0] ^ (i >= 3), ea[i % 3]}) begin
          errors++;
          $display("FAIL b2b_addr[%0d]: bank/addr=%0d/%0d, expected %0d/%0d", i, rd_q[i][10], rd_q[i][9:0], b[0] ^ (i >= 3), ea[i % 3]);
        end
      end
      if (emp_cyc.size() > 0) begin
        vectors++;
        if (rd_cyc[3] != emp_cyc[0] + 3) begin
          errors++;
          $display("FAIL b2b_restart: second frame first read at +%0d, expected +3", rd_cyc[3] - emp_cyc[0]);
        end
      end
    end
    vectors++;
    if (obank !== b[0]) begin errors++; $display("FAIL b2b_bank_after: obank=%b, expected %b", obank, b[0]); end
  endtask

  task automatic test_clkena_stall();
    logic [4:0] et[$];
    logic [9:0] ea[$];
    et = {5'b11000, 5'b00000, 5'b00100, 5'b01001, 5'b00111};
    ea = {10'd0, 10'd1, 10'd2, 10'd512, 10'd513};
    test_frame_seq("stall", 3, 2, 0, 1, et, ea);
  endtask

  task automatic test_reset_mid_frame();
    bit hit;
    logic [4:0] et[$];
    logic [9:0] ea[$];
    hit = 0;
    clear_mon();
    iused_data_col = 8'd3;
    iused_row = 9'd3;
    ibuf_full = 1;
    for (int i = 0; i < 100 && !hit; i++) begin
      tick();
      if (obusy) ibuf_full = 0;
      if (oread && oaddr == 10'd513) hit = 1;
    end
    vectors++;
    if (!hit) begin errors++; $display("FAIL rst_mid_reach: parity read 513 not seen, expected seen"); end
    vectors++;
    if (obank !== 1'b1) begin errors++; $display("FAIL rst_mid_bank_before: obank=%b, expected 1", obank); end
    #2 ireset = 0;
    #1;
    vectors++;
    if ({oread, oval, osof, osop, oeop, oeof, opar, obuf_empty} !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_strobes: got %b, expected 00000000", {oread, oval, osof, osop, oeop, oeof, opar, obuf_empty});
    end
    vectors++;
    if ({obank, oaddr} !== 11'd0) begin errors++; $display("FAIL rst_mid_bank_addr: obank/oaddr=%b/%0d, expected 0/0", obank, oaddr); end
    tick();
    tick();
    ireset = 1;
    exp_bank = 0;
    tick();
    vectors++;
    if (obusy !== 1'b0) begin errors++; $display("FAIL rst_mid_wait: obusy=%b, expected 0", obusy); end
    vectors++;
    if (emp_cyc.size() != 0) begin errors++; $display("FAIL rst_mid_no_release: obuf_empty pulses=%0d, expected 0", emp_cyc.size()); end
    et = {5'b11100, 5'b01111};
    ea = {10'd0, 10'd512};
    test_frame_seq("restart", 1, 1, 0, 0, et, ea);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ready_gaps();
    test_min_frame();
    test_back_to_back();
    test_clkena_stall();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
